// File: rtl/s_p_conv.sv
// s_p_conv: serial-to-parallel word assembler.
// Bits arrive MSB-first, qualified by serial_en. frame_sync marks the first bit
// of a word. A completed word is published on par_out with a one-cycle
// s_p_flag_out pulse. A frame_sync arriving mid-word abandons the partial word,
// sets a sticky frame_err and starts a new word with the frame_sync bit.
module s_p_conv #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              serial_in,
    input  logic              serial_en,
    input  logic              frame_sync,
    output logic [DATA_W-1:0] par_out,
    output logic              s_p_flag_out,
    output logic              busy,
    output logic              frame_err
);

    localparam int CW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state;
    logic [DATA_W-1:0] sr;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] sr_shift;
    logic [DATA_W-1:0] sr_first;

    // Candidate shift-register values: append the incoming bit, or start fresh.
    assign sr_shift = {sr[DATA_W-2:0], serial_in};
    assign sr_first = {{(DATA_W-1){1'b0}}, serial_in};

    // Word-assembly FSM; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            sr           <= '0;
            cnt          <= '0;
            par_out      <= '0;
            s_p_flag_out <= 1'b0;
            busy         <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            s_p_flag_out <= 1'b0;
            case (state)
                IDLE: begin
                    // Bits without frame_sync are dropped until a word starts.
                    if (serial_en && frame_sync) begin
                        sr    <= sr_first;
                        cnt   <= CW'(1);
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (serial_en) begin
                        if (frame_sync) begin
                            // Resync: abandon the partial word, keep par_out.
                            sr        <= sr_first;
                            cnt       <= CW'(1);
                            frame_err <= 1'b1;
                        end else if (cnt == LAST_CNT) begin
                            // This bit completes the word.
                            sr           <= sr_shift;
                            par_out      <= sr_shift;
                            s_p_flag_out <= 1'b1;
                            cnt          <= '0;
                            state        <= IDLE;
                            busy         <= 1'b0;
                        end else begin
                            sr  <= sr_shift;
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s_p_conv.sv
// tb_s_p_conv: randomized and directed checks of s_p_conv against a
// queue-based word model, plus literal expectations for the directed words.
module tb_s_p_conv;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              serial_in = 1'b0;
    logic              serial_en = 1'b0;
    logic              frame_sync = 1'b0;
    logic [DATA_W-1:0] par_out;
    logic              s_p_flag_out;
    logic              busy;
    logic              frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state: bits of the word in progress, and expected outputs.
    logic              q[$];
    logic [DATA_W-1:0] exp_par = '0;
    logic              exp_flag = 1'b0;
    logic              exp_busy = 1'b0;
    logic              exp_err = 1'b0;

    // Observed pulses: cycle number and par_out at each.
    int                pulses[$];
    logic [DATA_W-1:0] pvals[$];

    s_p_conv #(.DATA_W(DATA_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .serial_in(serial_in),
        .serial_en(serial_en),
        .frame_sync(frame_sync),
        .par_out(par_out),
        .s_p_flag_out(s_p_flag_out),
        .busy(busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a word is the list of accepted bits since frame_sync.
    always @(posedge clk) begin
        cyc++;
        exp_flag = 1'b0;
        if (!rst_n) begin
            q.delete();
            exp_par = '0;
            exp_err = 1'b0;
        end else if (serial_en) begin
            if (frame_sync) begin
                if (q.size() > 0) exp_err = 1'b1;
                q.delete();
                q.push_back(serial_in);
            end else if (q.size() > 0) begin
                q.push_back(serial_in);
                if (q.size() == DATA_W) begin
                    exp_par = '0;
                    foreach (q[i]) exp_par = {exp_par[DATA_W-2:0], q[i]};
                    exp_flag = 1'b1;
                    q.delete();
                end
            end
        end
        exp_busy = (q.size() > 0);
    end

    // Every-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("par_out", 64'(par_out), 64'(exp_par));
            chk("s_p_flag_out", 64'(s_p_flag_out), 64'(exp_flag));
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("frame_err", 64'(frame_err), 64'(exp_err));
            if (s_p_flag_out === 1'b1) begin
                pulses.push_back(cyc);
                pvals.push_back(par_out);
            end
        end
    end

    // Apply one cycle of inputs (changed on the falling edge).
    task automatic drive(input logic r, input logic en, input logic fs, input logic b);
        @(negedge clk);
        rst_n      = r;
        serial_en  = en;
        frame_sync = fs;
        serial_in  = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'($urandom), 1'($urandom));
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w, input bit gapped);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            drive(1'b1, 1'b1, (i == DATA_W - 1), w[i]);
            if (gapped && i > 0) drive(1'b1, 1'b0, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic do_reset();
        drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
        drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        logic [DATA_W-1:0] w;

        // Reset with random serial inputs.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_par", 64'(par_out), 64'h0);
        chk("rst_flag", 64'(s_p_flag_out), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_err", 64'(frame_err), 64'h0);

        // Single word, contiguous.
        pulses.delete(); pvals.delete();
        send_word(32'hA5A50F3C, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("single_pulse_now", 64'(s_p_flag_out), 64'h1);
        chk("single_busy_low", 64'(busy), 64'h0);
        chk("single_par", 64'(par_out), 64'hA5A50F3C);
        chk("single_model_par", 64'(exp_par), 64'hA5A50F3C);
        idle(3);
        chk("single_npulse", 64'(pulses.size()), 64'h1);

        // Same word with a gap after every enabled bit.
        pulses.delete(); pvals.delete();
        send_word(32'hA5A50F3C, 1'b1);
        chk("gap_no_early_pulse", 64'(pulses.size()), 64'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("gap_pulse_now", 64'(s_p_flag_out), 64'h1);
        chk("gap_par", 64'(par_out), 64'hA5A50F3C);
        idle(3);
        chk("gap_npulse", 64'(pulses.size()), 64'h1);

        // Resync at bit 10, then a full word.
        pulses.delete(); pvals.delete();
        w = 32'($urandom);
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, (i == 0), w[i]);
        send_word(32'h12345678, 1'b0);
        idle(3);
        chk("resync_err", 64'(frame_err), 64'h1);
        chk("resync_npulse", 64'(pulses.size()), 64'h1);
        chk("resync_par", 64'(par_out), 64'h12345678);
        chk("resync_model_par", 64'(exp_par), 64'h12345678);

        // Back-to-back words with no idle cycle.
        pulses.delete(); pvals.delete();
        send_word(32'hDEADBEEF, 1'b0);
        send_word(32'h0000FFFF, 1'b0);
        idle(3);
        chk("b2b_npulse", 64'(pulses.size()), 64'h2);
        if (pulses.size() == 2) begin
            chk("b2b_spacing", 64'(pulses[1] - pulses[0]), 64'd32);
            chk("b2b_par0", 64'(pvals[0]), 64'hDEADBEEF);
            chk("b2b_par1", 64'(pvals[1]), 64'h0000FFFF);
        end

        // Reset mid-word after 20 bits, then a clean word.
        do_reset();
        pulses.delete(); pvals.delete();
        w = 32'($urandom);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, (i == 0), w[i]);
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rstmid_busy", 64'(busy), 64'h0);
        chk("rstmid_par", 64'(par_out), 64'h0);
        chk("rstmid_npulse", 64'(pulses.size()), 64'h0);
        send_word(32'hCAFEF00D, 1'b0);
        idle(3);
        chk("rstmid_next_npulse", 64'(pulses.size()), 64'h1);
        chk("rstmid_next_par", 64'(par_out), 64'hCAFEF00D);

        // Randomized traffic with occasional resyncs and resets.
        for (int i = 0; i < 4000; i++)
            drive(($urandom_range(0, 499) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 39) == 0), 1'($urandom));
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
